// File: rtl/fg_profile_sequencer_pkg.sv
// Shared types and constants for the function-generator profile sequencer
// and its profile register file.
package fg_profile_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

  // Host address layout: {profile, byte}; config bytes first, dwell bytes after.
  localparam int BYTE_SEL_W       = 4;
  localparam int CONFIG_BYTE_BASE = 0;
  localparam int DWELL_BYTE_BASE  = 8;

  // Config bus field positions as decoded by the generator.
  localparam int CR_CS_BIT          = 63;
  localparam int CR_MS_BIT          = 62;
  localparam int CR_RADIX_LSB       = 60;
  localparam int CR_RADIX_W         = 2;
  localparam int CR_PRESCALER_LSB   = 48;
  localparam int CR_PRESCALER_W     = 12;
  localparam int CR_COUNTER_LSB     = 40;
  localparam int CR_COUNTER_W       = 8;
  localparam int CR_PHASE_LSB       = 32;
  localparam int CR_PHASE_W         = 8;
  localparam int CR_SLOPE_UP_LSB    = 24;
  localparam int CR_SLOPE_DN_LSB    = 16;
  localparam int CR_SLOPE_W         = 8;
  localparam int CR_AMPLITUDE_LSB   = 8;
  localparam int CR_AMPLITUDE_W     = 8;
  localparam int CR_OFFSET_LSB      = 0;
  localparam int CR_OFFSET_W        = 8;

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/fg_profile_mem.sv
// Byte-writable register file of PROFILE_COUNT profiles (config + dwell),
// read combinationally by profile index.
module fg_profile_mem
  import fg_profile_sequencer_pkg::*;
#(
  parameter int CONFIG_REG_BITWIDTH = 64,
  parameter int PROFILE_COUNT       = 4,
  parameter int DWELL_BITWIDTH      = 16,
  localparam int IDX_W              = $clog2(PROFILE_COUNT)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           wr_en_i,
  input  logic [IDX_W+BYTE_SEL_W-1:0]    wr_addr_i,
  input  logic [7:0]                     wr_data_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] cfg_o,
  output logic [DWELL_BITWIDTH-1:0]      dwell_o
);

  localparam int CFG_BYTES   = CONFIG_REG_BITWIDTH / 8;
  localparam int DWELL_BYTES = bytes_for(DWELL_BITWIDTH);
  localparam int DWELL_PAD_W = DWELL_BYTES * 8;

  logic [PROFILE_COUNT-1:0][CONFIG_REG_BITWIDTH-1:0] cfg_mem;
  logic [PROFILE_COUNT-1:0][DWELL_PAD_W-1:0]         dwell_mem;
  logic [IDX_W-1:0]                                  wr_prof;
  logic [BYTE_SEL_W-1:0]                             wr_byte;

  assign wr_byte = wr_addr_i[BYTE_SEL_W-1:0];
  assign wr_prof = wr_addr_i[BYTE_SEL_W +: IDX_W];

  // Byte lanes outside the config and dwell windows are silently dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_mem   <= '0;
      dwell_mem <= '0;
    end else if (wr_en_i) begin
      for (int b = 0; b < CFG_BYTES; b++) begin
        if (wr_byte == BYTE_SEL_W'(CONFIG_BYTE_BASE + b))
          cfg_mem[wr_prof][b*8 +: 8] <= wr_data_i;
      end
      for (int b = 0; b < DWELL_BYTES; b++) begin
        if (wr_byte == BYTE_SEL_W'(DWELL_BYTE_BASE + b))
          dwell_mem[wr_prof][b*8 +: 8] <= wr_data_i;
      end
    end
  end

  assign cfg_o   = cfg_mem[rd_idx_i];
  assign dwell_o = dwell_mem[rd_idx_i][DWELL_BITWIDTH-1:0];

endmodule

// File: rtl/fg_profile_sequencer.sv
// Plays stored generator profiles in order, each for a programmed number of
// output-valid strobes, driving a shadowed config bus and the generator enable.
module fg_profile_sequencer
  import fg_profile_sequencer_pkg::*;
#(
  parameter int CONFIG_REG_BITWIDTH = 64,
  parameter int PROFILE_COUNT       = 4,
  parameter int DWELL_BITWIDTH      = 16,
  parameter int SETTLE_CYCLES       = 3
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               wr_en_i,
  input  logic [$clog2(PROFILE_COUNT)+3:0]   wr_addr_i,
  input  logic [7:0]                         wr_data_i,
  input  logic                               start_i,
  input  logic                               stop_i,
  input  logic                               loop_i,
  input  logic                               outValid_STRB_i,
  output logic [CONFIG_REG_BITWIDTH-1:0]     CR_bus_o,
  output logic                               outputEnable_o,
  output logic [$clog2(PROFILE_COUNT)-1:0]   activeProfile_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int IDX_W    = $clog2(PROFILE_COUNT);
  localparam int SKIP_W   = IDX_W + 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(PROFILE_COUNT - 1);
  localparam logic [SKIP_W-1:0]   SKIP_LIMIT  = SKIP_W'(PROFILE_COUNT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [SKIP_W-1:0]              skip_q, skip_d;
  logic [SETTLE_W-1:0]            settle_q, settle_d;
  logic [DWELL_BITWIDTH-1:0]      strobe_q, strobe_d, strobe_inc;
  logic [DWELL_BITWIDTH-1:0]      dwell_q, dwell_d;
  logic [CONFIG_REG_BITWIDTH-1:0] cr_q, cr_d;
  logic [IDX_W-1:0]               act_q, act_d;
  logic                           en_q;
  logic                           done_q, done_d;
  logic [CONFIG_REG_BITWIDTH-1:0] mem_cfg;
  logic [DWELL_BITWIDTH-1:0]      mem_dwell;

  fg_profile_mem #(
    .CONFIG_REG_BITWIDTH(CONFIG_REG_BITWIDTH),
    .PROFILE_COUNT      (PROFILE_COUNT),
    .DWELL_BITWIDTH     (DWELL_BITWIDTH)
  ) u_mem (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_idx_i (idx_q),
    .cfg_o    (mem_cfg),
    .dwell_o  (mem_dwell)
  );

  assign strobe_inc = strobe_q + 1'b1;

  // Stop wins over everything and freezes the shadowed config and index.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    skip_d   = skip_q;
    settle_d = settle_q;
    strobe_d = strobe_q;
    dwell_d  = dwell_q;
    cr_d     = cr_q;
    act_d    = act_q;
    done_d   = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d  = ST_LOAD;
            idx_d    = '0;
            skip_d   = '0;
            strobe_d = '0;
          end
        end
        ST_LOAD: begin
          if (mem_dwell == '0) begin
            if (skip_q == SKIP_LIMIT || (idx_q == LAST_IDX && !loop_i)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_q + 1'b1;
              skip_d = skip_q + 1'b1;
            end
          end else begin
            cr_d     = mem_cfg;
            act_d    = idx_q;
            dwell_d  = mem_dwell;
            skip_d   = '0;
            settle_d = '0;
            state_d  = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_RUN;
          else                         settle_d = settle_q + 1'b1;
        end
        ST_RUN: begin
          if (outValid_STRB_i) begin
            if (strobe_inc == dwell_q) begin
              strobe_d = '0;
              if (idx_q != LAST_IDX || loop_i) begin
                idx_d   = idx_q + 1'b1;
                skip_d  = '0;
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              strobe_d = strobe_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Enable is registered from the next state so it rises exactly on RUN entry.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      skip_q   <= '0;
      settle_q <= '0;
      strobe_q <= '0;
      dwell_q  <= '0;
      cr_q     <= '0;
      act_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      skip_q   <= skip_d;
      settle_q <= settle_d;
      strobe_q <= strobe_d;
      dwell_q  <= dwell_d;
      cr_q     <= cr_d;
      act_q    <= act_d;
      en_q     <= (state_d == ST_RUN);
      done_q   <= done_d;
    end
  end

  assign CR_bus_o        = cr_q;
  assign outputEnable_o  = en_q;
  assign activeProfile_o = act_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;

endmodule

// File: tb/tb_fg_profile_sequencer.sv
// Self-checking bench for fg_profile_sequencer: a countdown-based profile
// player model checked every cycle, plus directed literal expectations.
module tb_fg_profile_sequencer;

  localparam int CW   = 64;
  localparam int PC   = 4;
  localparam int DW   = 16;
  localparam int SC   = 3;
  localparam int IW   = 2;
  localparam int LAST = PC - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [IW+3:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start, stop, loop_r, strobe;
  logic [CW-1:0] cr;
  logic          en;
  logic [IW-1:0] act;
  logic          busy, done;

  always #5 clk = ~clk;

  fg_profile_sequencer #(
    .CONFIG_REG_BITWIDTH(CW),
    .PROFILE_COUNT      (PC),
    .DWELL_BITWIDTH     (DW),
    .SETTLE_CYCLES      (SC)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .start_i        (start),
    .stop_i         (stop),
    .loop_i         (loop_r),
    .outValid_STRB_i(strobe),
    .CR_bus_o       (cr),
    .outputEnable_o (en),
    .activeProfile_o(act),
    .busy_o         (busy),
    .done_o         (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Profile player model: a sequence is either searching for a non-zero
  // dwell, counting down settle cycles, or counting down remaining strobes.
  logic [CW-1:0] m_cfg   [PC];
  logic [DW-1:0] m_dwell [PC];
  logic [CW-1:0] e_cr;
  logic          e_en, e_busy, e_done;
  int            e_act;
  bit            m_active, m_search;
  int            m_pos, m_tried, m_settle, m_left;
  int            wp, wb;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PC; i++) begin
        m_cfg[i]   = '0;
        m_dwell[i] = '0;
      end
      m_active = 0; m_search = 0; m_pos = 0; m_tried = 0;
      m_settle = 0; m_left = 0;
      e_cr = '0; e_act = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (stop) begin
        m_active = 0; m_search = 0; m_settle = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_search = 1; m_pos = 0; m_tried = 0;
        end
      end else if (m_search) begin
        if (m_dwell[m_pos] == 0) begin
          m_tried++;
          if (m_tried == PC || (m_pos == LAST && !loop_r)) begin
            m_active = 0; m_search = 0; e_done = 1;
          end else begin
            m_pos = (m_pos + 1) % PC;
          end
        end else begin
          e_cr = m_cfg[m_pos]; e_act = m_pos; m_left = int'(m_dwell[m_pos]);
          m_settle = SC; m_search = 0; m_tried = 0;
        end
      end else if (m_settle > 0) begin
        m_settle--;
      end else if (strobe) begin
        m_left--;
        if (m_left == 0) begin
          if (m_pos < LAST || loop_r) begin
            m_pos = (m_pos + 1) % PC; m_search = 1;
          end else begin
            m_active = 0; e_done = 1;
          end
        end
      end
      if (wr_en) begin
        wp = int'(wr_addr[IW+3:4]);
        wb = int'(wr_addr[3:0]);
        if (wb < 8)       m_cfg[wp][wb*8 +: 8] = wr_data;
        else if (wb == 8) m_dwell[wp][7:0]     = wr_data;
        else if (wb == 9) m_dwell[wp][15:8]    = wr_data;
      end
    end
    e_en   = m_active && !m_search && (m_settle == 0);
    e_busy = m_active;
  end

  // Event log used by the directed checks.
  logic          prev_en = 1'b0;
  int            done_cnt = 0, run_strobes = 0, en_cycles = 0;
  logic [CW-1:0] log_cr[$];
  int            log_act[$];

  always @(negedge clk) begin
    if (en && !prev_en) begin
      log_cr.push_back(cr);
      log_act.push_back(int'(act));
    end
    prev_en = en;
    if (done)          done_cnt++;
    if (en && strobe)  run_strobes++;
    if (en)            en_cycles++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic lp, input logic sb);
    @(posedge clk); #2;
    start = st; stop = sp; loop_r = lp; strobe = sb; wr_en = 1'b0;
  endtask

  task automatic writeByte(input int p, input int b, input logic [7:0] d);
    @(posedge clk); #2;
    start = 1'b0; stop = 1'b0; strobe = 1'b0;
    wr_en = 1'b1; wr_addr = {IW'(p), 4'(b)}; wr_data = d;
  endtask

  task automatic writeProfile(input int p, input logic [CW-1:0] cfg, input logic [DW-1:0] dw);
    for (int b = 0; b < 8; b++) writeByte(p, b, cfg[b*8 +: 8]);
    writeByte(p, 8, dw[7:0]);
    writeByte(p, 9, dw[15:8]);
  endtask

  task automatic waitEnable(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 1'b0, loop_r, 1'b0);
      if (en) return;
    end
    checkOutput(name, 64'd0, 64'd1);
  endtask

  task automatic strobeUntilDone(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 1'b0, loop_r, 1'b1);
      if (done) begin
        applyStimulus(1'b0, 1'b0, loop_r, 1'b0);
        return;
      end
    end
    checkOutput(name, 64'd0, 64'd1);
  endtask

  localparam logic [CW-1:0] CFG0 = 64'h8000_0000_0000_7F00;
  localparam logic [CW-1:0] CFG1 = 64'h4000_0A00_0000_4010;
  localparam logic [CW-1:0] CFGX = 64'hA5A5_0000_1234_5678;
  localparam logic [CW-1:0] CFGY = 64'h5A5A_FFFF_8765_4321;

  int base_log, base_done, base_str, base_en, c;

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_r = 1'b0; strobe = 1'b0;

    fork
      forever begin
        @(negedge clk);
        checkOutput("cr_bus",  cr,   e_cr);
        checkOutput("enable",  64'(en),   64'(e_en));
        checkOutput("profile", 64'(act),  64'(e_act));
        checkOutput("busy",    64'(busy), 64'(e_busy));
        checkOutput("done",    64'(done), 64'(e_done));
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_cr", cr, 64'd0);
    checkOutput("reset_en", 64'(en), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rstn = 1'b1;

    // Two profiles, no loop
    writeProfile(0, CFG0, 16'd3);
    writeByte(0, 12, 8'hAA);
    writeProfile(1, CFG1, 16'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("write_keeps_cr", cr, 64'd0);
    base_log = log_cr.size(); base_done = done_cnt; base_str = run_strobes;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load_busy", 64'(busy), 64'd1);
    checkOutput("load_cr_old", cr, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load_cr0", cr, CFG0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("settle_en_low", 64'(en), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("settle_en_high", 64'(en), 64'd1);
    strobeUntilDone("two_timeout", 60);
    checkOutput("two_run_strobes", 64'(run_strobes - base_str), 64'd5);
    checkOutput("two_done_count", 64'(done_cnt - base_done), 64'd1);
    checkOutput("two_loads", 64'(log_cr.size() - base_log), 64'd2);
    if (log_cr.size() - base_log == 2) begin
      checkOutput("two_cr_first", log_cr[base_log], CFG0);
      checkOutput("two_cr_second", log_cr[base_log+1], CFG1);
      checkOutput("two_act_second", 64'(log_act[base_log+1]), 64'd1);
    end

    // Zero-dwell skip
    writeProfile(0, 64'h1111, 16'd1);
    writeProfile(1, 64'h2222, 16'd0);
    writeProfile(2, 64'h3333, 16'd1);
    writeProfile(3, 64'h4444, 16'd1);
    base_log = log_cr.size(); base_done = done_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    strobeUntilDone("skip_timeout", 60);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("skip_done_count", 64'(done_cnt - base_done), 64'd1);
    checkOutput("skip_loads", 64'(log_cr.size() - base_log), 64'd3);
    if (log_cr.size() - base_log == 3) begin
      checkOutput("skip_act0", 64'(log_act[base_log]),   64'd0);
      checkOutput("skip_act1", 64'(log_act[base_log+1]), 64'd2);
      checkOutput("skip_act2", 64'(log_act[base_log+2]), 64'd3);
    end

    // All dwell zero with loop
    for (int p = 0; p < PC; p++) begin
      writeByte(p, 8, 8'h00);
      writeByte(p, 9, 8'h00);
    end
    base_done = done_cnt; base_en = en_cycles;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (c = 1; c <= PC + 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (done) break;
    end
    checkOutput("allzero_latency_ok", 64'(c <= PC + 1), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("allzero_done", 64'(done_cnt - base_done), 64'd1);
    checkOutput("allzero_no_en", 64'(en_cycles - base_en), 64'd0);
    checkOutput("allzero_cr_held", cr, 64'h4444);
    checkOutput("allzero_idle", 64'(busy), 64'd0);

    // Host write to the running profile, visible only after the wrap
    writeProfile(0, CFGX, 16'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitEnable("runx_timeout", 20);
    checkOutput("run_cr_x", cr, CFGX);
    for (int b = 0; b < 8; b++) writeByte(0, b, CFGY[b*8 +: 8]);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("run_cr_held", cr, CFGX);
    checkOutput("run_en_held", 64'(en), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEnable("wrap_timeout", 20);
    checkOutput("wrap_cr_y", cr, CFGY);
    checkOutput("wrap_act", 64'(act), 64'd0);

    // Stop and strobe together in RUN, then start with stop in IDLE
    base_done = done_cnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stop_busy", 64'(busy), 64'd0);
    checkOutput("stop_en", 64'(en), 64'd0);
    checkOutput("stop_cr_held", cr, CFGY);
    checkOutput("stop_no_done", 64'(done_cnt - base_done), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("startstop_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitEnable("rst_run_timeout", 20);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_cr", cr, 64'd0);
    checkOutput("async_rst_en", 64'(en), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fg_profile_sequencer.md
Name: fg_profile_sequencer

Overview:
- Holds PROFILE_COUNT configuration profiles for the function generator and plays them in order, each for a programmed number of output-valid strobes. Supports frequency/amplitude sweeps and burst patterns.
- Drives the generator's 64-bit config bus and output enable, and counts its outValid strobe.
- Profiles are written byte-wise from the host register interface. The active config is shadowed, so host writes never glitch a running profile.

Parameters:
- CONFIG_REG_BITWIDTH, 64, width of config bus (multiple of 8).
- PROFILE_COUNT, 4, number of stored profiles (power of 2, >=2).
- DWELL_BITWIDTH, 16, strobe-count width per profile.
- SETTLE_CYCLES, 3, enable-low cycles after each config change (covers generator reset sync + config-change reset).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous, active-low reset
- wr_en_i  in  1  byte write strobe
- wr_addr_i  in  $clog2(PROFILE_COUNT)+4  {profile, byte}; byte 0..7 = config bytes LSB first, 8..9 = dwell LSB first, 10..15 ignored
- wr_data_i  in  8  write data
- start_i  in  1  begin sequence at profile 0 (level sampled, acts in IDLE only)
- stop_i  in  1  abort to IDLE
- loop_i  in  1  wrap from last profile to profile 0 instead of finishing
- outValid_STRB_i  in  1  generator output-valid strobe
- CR_bus_o  out  CONFIG_REG_BITWIDTH  config bus to generator (registered)
- outputEnable_o  out  1  generator enable (registered)
- activeProfile_o  out  $clog2(PROFILE_COUNT)  index of latched profile
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse on normal sequence end

Behaviour:
- Reset values: CR_bus_o=0, outputEnable_o=0, activeProfile_o=0, busy_o=0, done_o=0, state IDLE, profile memory and dwell counter cleared to 0.
- Memory writes are accepted in every state and take effect 1 cycle after wr_en_i. They never alter CR_bus_o directly; only LOAD copies memory to CR_bus_o.
- States:
  - IDLE: outputEnable_o=0; CR_bus_o holds its last value. start_i=1 and stop_i=0 -> LOAD with index 0.
  - LOAD (1 cycle):
    - If dwell[index]==0: skip to the next index (wrap rules below) and stay in LOAD; skip counter +1.
    - Else: CR_bus_o<=config[index], activeProfile_o<=index, skip counter cleared, -> SETTLE.
  - SETTLE: outputEnable_o=0 for exactly SETTLE_CYCLES cycles, then -> RUN.
  - RUN: outputEnable_o=1. Each outValid_STRB_i increments the strobe counter. The strobe that reaches dwell[index] ends the profile:
    - index<last, or loop_i=1: next index (wrap to 0), -> LOAD.
    - index==last and loop_i=0: -> IDLE, done_o pulse.
- Latency: start_i sampled at edge k -> LOAD during k..k+1 -> CR_bus_o valid after edge k+1 -> outputEnable_o=1 after edge k+1+SETTLE_CYCLES.
- Strobes arriving in LOAD/SETTLE/IDLE are ignored. The strobe counter clears on entering LOAD.
- Dwell is sampled from memory at LOAD. Host changes to the running profile's dwell apply on its next LOAD.
- All-zero guard: skip counter reaches PROFILE_COUNT -> IDLE with done_o pulse, CR_bus_o unchanged.
- stop_i (any state, priority over start_i and strobe): -> IDLE next cycle, outputEnable_o=0 next cycle, no done_o, CR_bus_o held.
- Reset mid-run: all outputs return to reset values asynchronously.
- loop_i is sampled only at profile end.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, SETTLE, RUN), address field widths/offsets (BYTE_SEL_W=4, DWELL_BYTE_BASE=8), config bit-position constants shared with the generator (CS/MS/Radix, prescaler, counter, phase, slopes, amplitude, offset).
- One natural sub-module: fg_profile_mem. It holds the byte-writable PROFILE_COUNT x (config+dwell) register file, with combinational read by index.

Test Plan:
- Reset then idle: assert rstn_i=0 mid-RUN -> CR_bus_o=0, outputEnable_o=0, busy_o=0 immediately.
- Two profiles: write profile0 config 0x8000_0000_0000_7F00 with dwell 3, profile1 config 0x4000_0A00_0000_4010 with dwell 2; pulse start_i, loop_i=0 -> CR_bus_o shows profile0, enable after 3 settle cycles, switches after 3 strobes, then profile1; done_o after 2 more strobes; 5 RUN-state strobes total.
- Zero-dwell skip: profile1 dwell 0, profiles 0/2/3 dwell 1 -> activeProfile_o sequence 0,2,3, done_o once.
- All dwell 0 with loop_i=1 -> returns to IDLE within PROFILE_COUNT+1 cycles, done_o=1, outputEnable_o never 1.
- Write during RUN to active profile config -> CR_bus_o unchanged until next LOAD; with loop_i=1 the new value appears on wrap.
- stop_i and strobe in same cycle in RUN -> IDLE, no profile advance, no done_o; start_i together with stop_i in IDLE -> stays IDLE.
